loop_counter_ctrl: RTL and testbench
====================================

Name: loop_counter_ctrl

Overview:
- Parametrised loadable down-counter with an internal reload mux, start/done handshake, pause, abort and optional auto-reload looping.
- Replaces the external "initial vs current count" select in lab datapaths.
- The FSM owns the load decision and runs one countdown, or repeats countdowns, from a latched initial value.
- Sits between the control unit (start/abort/pause) and display/compare logic (count, done, loops).

Parameters:
- WIDTH, 10, bit width of initial_count and count.
- LOOP_W, 4, bit width of the completed-loop counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin countdown; sampled only in IDLE.
- initial_count  input  WIDTH  load value, latched on accepted start.
- auto_reload  input  1  1 = reload and repeat on reaching zero; 0 = single shot. Sampled each cycle.
- pause  input  1  freeze count while high in RUN.
- abort  input  1  return to IDLE; count holds its value.
- count  output  WIDTH  current count value.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle pulse at each countdown completion.
- loops  output  LOOP_W  completed countdowns since last start; saturates at all-ones.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, count=0, init_reg=0, busy=0, done=0, loops=0.
- States: IDLE, RUN, PAUSE. All outputs are registered.
- busy is decoded from the registered state.
- IDLE:
  - start=1 → init_reg<=initial_count, count<=initial_count, loops<=0, go RUN.
  - busy is high from the next cycle.
- RUN:
  - Priority order: abort > pause > count action.
  - abort → IDLE, count unchanged, done=0.
  - pause → PAUSE, count unchanged.
  - count!=0 → count<=count-1.
  - count==0 → done<=1 for exactly one cycle, and loops<=loops+1 (saturating).
    - If auto_reload=1: count<=init_reg, stay RUN.
    - Else: go IDLE, count stays 0.
- PAUSE:
  - abort → IDLE.
  - pause=0 → RUN; counting resumes on the following edge.
  - Otherwise hold all registers.
- Latency: start accepted on edge k. count=N after k, reaches 0 after edge k+N, and done is high after edge k+N+1.
  - Countdown period is N+1 cycles; an auto-reload loop repeats every N+1 cycles.
- initial_count=0: done pulses on the second edge after start. With auto_reload=1, done pulses every cycle.
- start outside IDLE is ignored; it does not restart, and initial_count changes are ignored until the next accepted start.
- Single-shot completion and start in the same cycle: the FSM is in RUN, so start is ignored; start must be reasserted in IDLE.
- No wrap-around: count never decrements below 0.
- auto_reload deasserted mid-loop: the current countdown finishes, then the FSM goes to IDLE.
- Reset mid-operation: immediate return to reset values. No done pulse is generated.

Test Plan:
- Reset and single shot: rst_n low, then start with initial_count=3, auto_reload=0.
  - Required: count 3,2,1,0 on successive cycles; done=1 one cycle later with loops=1; busy drops; count holds 0.
- Auto-reload: initial_count=2, auto_reload=1, run 9 cycles after start.
  - Required: count 2,1,0,2,1,0,2,1,0; done pulses every 3 cycles; loops=1,2,3.
- Pause and abort: initial_count=5, pause 2 cycles while count=3.
  - Required: count holds 3 for the pause, then resumes at 2.
  - Then assert abort and pause together at count=1. Required: IDLE, count=1, busy=0, no done.
- Zero load and saturation: initial_count=0, auto_reload=1, LOOP_W=4, run 20 cycles.
  - Required: done high every cycle after the first, and loops saturates at 15.
- Ignored start and async reset: while RUN at count=4, assert start with initial_count=9.
  - Required: count continues 3,2...
  - Then drop rst_n mid-count, asynchronously between edges. Required: count, busy, done and loops read 0 immediately.

Source files
------------

// File: rtl/loop_counter_ctrl.sv
// Loadable down-counter with latched reload value, start/done handshake,
// pause, abort and optional auto-reload looping with a saturating loop count.
module loop_counter_ctrl #(
  parameter int WIDTH  = 10,
  parameter int LOOP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  initial_count,
  input  logic              auto_reload,
  input  logic              pause,
  input  logic              abort,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [LOOP_W-1:0] loops
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  localparam logic [LOOP_W-1:0] LOOPS_MAX = '1;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  count_q, count_nxt;
  logic [WIDTH-1:0]  init_reg, init_nxt;
  logic              done_q, done_nxt;
  logic [LOOP_W-1:0] loops_q, loops_nxt;
  logic              at_zero;

  assign at_zero = (count_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count_q  <= '0;
      init_reg <= '0;
      done_q   <= 1'b0;
      loops_q  <= '0;
    end else begin
      state    <= state_nxt;
      count_q  <= count_nxt;
      init_reg <= init_nxt;
      done_q   <= done_nxt;
      loops_q  <= loops_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        if (abort)                          state_nxt = IDLE;
        else if (pause)                     state_nxt = PAUSE;
        else if (at_zero && !auto_reload)   state_nxt = IDLE;
      end
      PAUSE: begin
        if (abort)       state_nxt = IDLE;
        else if (!pause) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless the
  // current state acts on it, and done is a single-cycle pulse.
  always_comb begin
    count_nxt = count_q;
    init_nxt  = init_reg;
    loops_nxt = loops_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          init_nxt  = initial_count;
          count_nxt = initial_count;
          loops_nxt = '0;
        end
      end
      RUN: begin
        if (!abort && !pause) begin
          if (!at_zero) begin
            count_nxt = count_q - WIDTH'(1);
          end else begin
            done_nxt = 1'b1;
            if (loops_q != LOOPS_MAX) loops_nxt = loops_q + LOOP_W'(1);
            if (auto_reload) count_nxt = init_reg;
          end
        end
      end
      default: ;
    endcase
  end

  assign count = count_q;
  assign busy  = (state != IDLE);
  assign done  = done_q;
  assign loops = loops_q;

endmodule

// File: tb/tb_loop_counter_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_loop_counter_ctrl;
  localparam int WIDTH  = 10;
  localparam int LOOP_W = 4;
  localparam int LMAX   = (1 << LOOP_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  initial_count = '0;
  logic              auto_reload = 1'b0;
  logic              pause = 1'b0;
  logic              abort = 1'b0;
  logic [WIDTH-1:0]  count;
  logic              busy;
  logic              done;
  logic [LOOP_W-1:0] loops;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  loop_counter_ctrl #(.WIDTH(WIDTH), .LOOP_W(LOOP_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .initial_count(initial_count),
    .auto_reload(auto_reload), .pause(pause), .abort(abort),
    .count(count), .busy(busy), .done(done), .loops(loops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 counting, 2 paused.
  int m_mode, m_count, m_init, m_loops;
  bit m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_count = 0; m_init = 0; m_loops = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_mode == 0) begin
        if (start) begin
          m_init = int'(initial_count); m_count = m_init; m_loops = 0; m_mode = 1;
        end
      end else if (abort) begin
        m_mode = 0;
      end else if (m_mode == 2) begin
        if (!pause) m_mode = 1;
      end else if (pause) begin
        m_mode = 2;
      end else if (m_count > 0) begin
        m_count = m_count - 1;
      end else begin
        m_done  = 1;
        m_loops = (m_loops < LMAX) ? m_loops + 1 : LMAX;
        if (auto_reload) m_count = m_init;
        else             m_mode = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_count", int'(count), m_count);
      chk("model_busy",  int'(busy),  (m_mode != 0) ? 1 : 0);
      chk("model_done",  int'(done),  int'(m_done));
      chk("model_loops", int'(loops), m_loops);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic go(input int n, input bit ar);
    initial_count = WIDTH'(n); auto_reload = ar; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int exp_cnt[9];
    exp_cnt = '{2, 1, 0, 2, 1, 0, 2, 1, 0};

    // reset
    repeat (2) tick();
    chk("rst_count", int'(count), 0);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_done",  int'(done),  0);
    chk("rst_loops", int'(loops), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // single shot of 3
    go(3, 1'b0);
    chk("ss_load", int'(count), 3);
    chk("ss_busy", int'(busy), 1);
    for (int v = 2; v >= 0; v--) begin
      tick(); chk("ss_count", int'(count), v);
    end
    chk("ss_nodone_at0", int'(done), 0);
    tick();
    chk("ss_done",  int'(done),  1);
    chk("ss_loops", int'(loops), 1);
    chk("ss_idle",  int'(busy),  0);
    chk("ss_hold0", int'(count), 0);
    tick();
    chk("ss_pulse", int'(done), 0);

    // auto-reload of 2
    initial_count = 2; auto_reload = 1'b1; start = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick(); start = 1'b0;
      chk("ar_count", int'(count), exp_cnt[e-1]);
      chk("ar_done",  int'(done), (e == 4 || e == 7) ? 1 : 0);
    end
    tick();
    chk("ar_done3",  int'(done),  1);
    chk("ar_loops3", int'(loops), 3);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ar_abort_idle", int'(busy), 0);

    // pause at 3, then abort+pause at 1
    go(5, 1'b0);
    tick(); tick();
    chk("pa_pre", int'(count), 3);
    pause = 1'b1; tick(); tick();
    chk("pa_hold", int'(count), 3);
    chk("pa_busy", int'(busy), 1);
    pause = 1'b0; tick();
    chk("pa_resume_edge", int'(count), 3);
    tick(); chk("pa_resumed", int'(count), 2);
    tick(); chk("pa_at1", int'(count), 1);
    abort = 1'b1; pause = 1'b1; tick();
    abort = 1'b0; pause = 1'b0;
    chk("ab_count", int'(count), 1);
    chk("ab_busy",  int'(busy),  0);
    chk("ab_done",  int'(done),  0);
    tick();
    chk("ab_nodone", int'(done), 0);

    // zero load with auto-reload: done every cycle, loops saturate
    go(0, 1'b1);
    chk("z_first_nodone", int'(done), 0);
    for (int e = 2; e <= 20; e++) begin
      tick();
      chk("z_done",  int'(done), 1);
      chk("z_loops", int'(loops), (e - 1 < LMAX) ? e - 1 : LMAX);
    end
    chk("z_sat", int'(loops), 15);
    abort = 1'b1; tick(); abort = 1'b0; auto_reload = 1'b0;

    // ignored start, then asynchronous reset mid-count
    go(7, 1'b0);
    tick(); tick(); tick();
    chk("ig_at4", int'(count), 4);
    initial_count = 9; start = 1'b1; tick();
    chk("ig_count3", int'(count), 3);
    start = 1'b0; tick();
    chk("ig_count2", int'(count), 2);
    #2 rst_n = 1'b0; #1;
    chk("ar_rst_count", int'(count), 0);
    chk("ar_rst_busy",  int'(busy),  0);
    chk("ar_rst_done",  int'(done),  0);
    chk("ar_rst_loops", int'(loops), 0);
    tick(); rst_n = 1'b1; tick();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      start         = ($urandom_range(0, 3) == 0);
      initial_count = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
      auto_reload   = ($urandom_range(0, 2) != 0);
      pause         = ($urandom_range(0, 7) == 0);
      abort         = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 300) == 0) begin
        #2 rst_n = 1'b0; #1;
        chk("rnd_rst_count", int'(count), 0);
        chk("rnd_rst_busy",  int'(busy),  0);
        tick(); rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    start = 1'b0; pause = 1'b0; abort = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
